// File: rtl/ii_sii_gen_if.sv
// Pixel-in / ii-out / sii-out stream bundle for the integral-image generator.
// Every stream transfers on valid & ready. A source holds data and eot stable
// while valid is high, and does not wait for ready before raising valid.
// The sink may drive ready independently of valid.
interface ii_sii_gen_if #(
  parameter int W_PIX = 8,
  parameter int W_II  = 18,
  parameter int W_SII = 26
);
  logic             pix_valid;
  logic             pix_ready;
  logic [W_PIX-1:0] pix_data;
  logic             ii_valid;
  logic             ii_ready;
  logic [W_II-1:0]  ii_data;
  logic [1:0]       ii_eot;
  logic             sii_valid;
  logic             sii_ready;
  logic [W_SII-1:0] sii_data;
  logic [1:0]       sii_eot;

  // Environment side: produces pixels, consumes ii/sii.
  modport master (
    output pix_valid, pix_data, ii_ready, sii_ready,
    input  pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot
  );

  // Generator side: consumes pixels, produces ii/sii.
  modport slave (
    input  pix_valid, pix_data, ii_ready, sii_ready,
    output pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot
  );
endinterface

// File: rtl/ii_sii_gen.sv
// Streaming integral-image generator. Takes raster-order pixels and emits one
// ii and one sii sample per pixel. There is one registered output stage.
// The previous row's ii/sii values are kept in a single-row line buffer.
module ii_sii_gen #(
  parameter int W_PIX      = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int W_II       = 18,
  parameter int W_SII      = 26
) (
  input  logic         clk,
  input  logic         rst,
  ii_sii_gen_if.slave  bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [W_II-1:0]    row_sum_q, rs_d, ii_d;
  logic [W_SII-1:0]   row_sqsum_q, rss_d, sii_d;
  logic               ii_valid_q, sii_valid_q;
  logic [W_II-1:0]    ii_data_q;
  logic [W_SII-1:0]   sii_data_q;
  logic [1:0]         eot_q, eot_d;
  logic [W_II-1:0]    lb_ii_q  [IMG_WIDTH];
  logic [W_SII-1:0]   lb_sii_q [IMG_WIDTH];
  logic [2*W_PIX-1:0] pix_sq;
  logic               pix_ready, accept, col_last, row_last;

  // A new pixel may enter only when both output registers are free or are being emptied in this cycle.
  assign pix_ready = (~ii_valid_q | bus.ii_ready) & (~sii_valid_q | bus.sii_ready);
  assign accept    = bus.pix_valid & pix_ready;

  assign bus.pix_ready = pix_ready;
  assign bus.ii_valid  = ii_valid_q;
  assign bus.ii_data   = ii_data_q;
  assign bus.ii_eot    = eot_q;
  assign bus.sii_valid = sii_valid_q;
  assign bus.sii_data  = sii_data_q;
  assign bus.sii_eot   = eot_q;

  // Compute the running row sums, the integral sums, framing flags and next position for the current pixel.
  always_comb begin
    pix_sq   = bus.pix_data * bus.pix_data;
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);
    rs_d     = ((col_q == '0) ? '0 : row_sum_q)   + W_II'(bus.pix_data);
    rss_d    = ((col_q == '0) ? '0 : row_sqsum_q) + W_SII'(pix_sq);
    // Row 0 never reads the line buffer, so its contents do not need clearing at reset.
    ii_d     = rs_d  + ((row_q == '0) ? '0 : lb_ii_q[col_q]);
    sii_d    = rss_d + ((row_q == '0) ? '0 : lb_sii_q[col_q]);
    eot_d    = {col_last & row_last, col_last};
    col_d    = col_last ? '0 : col_q + 1'b1;
    row_d    = row_q;
    if (col_last) begin
      row_d = row_last ? '0 : row_q + 1'b1;
    end
  end

  // Output registers, position counters and row sums. The ii and sii valids clear independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      ii_valid_q  <= 1'b0;
      sii_valid_q <= 1'b0;
      ii_data_q   <= '0;
      sii_data_q  <= '0;
      eot_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_sum_q   <= '0;
      row_sqsum_q <= '0;
    end else if (accept) begin
      ii_valid_q  <= 1'b1;
      sii_valid_q <= 1'b1;
      ii_data_q   <= ii_d;
      sii_data_q  <= sii_d;
      eot_q       <= eot_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_sum_q   <= rs_d;
      row_sqsum_q <= rss_d;
    end else begin
      if (bus.ii_ready)  ii_valid_q  <= 1'b0;
      if (bus.sii_ready) sii_valid_q <= 1'b0;
    end
  end

  // Line buffer: read earlier in the cycle at col, overwritten here with this row's value.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb_ii_q[col_q]  <= ii_d;
      lb_sii_q[col_q] <= sii_d;
    end
  end

endmodule

// File: tb/tb_ii_sii_gen.sv
// Directed bench for ii_sii_gen: reset state, all-ones/all-255 frames, output stall,
// back-to-back ramp frames, mid-frame reset, and a random-gap frame, all checked
// against a 2-D prefix-sum reference model.
module tb_ii_sii_gen;
  localparam int W_PIX = 8;
  localparam int IW    = 32;
  localparam int IH    = 32;
  localparam int W_II  = 18;
  localparam int W_SII = 26;
  localparam int NPIX  = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W_II+1:0]  ii_exp_q[$];
  logic [W_SII+1:0] sii_exp_q[$];
  logic [W_PIX-1:0] pix [NPIX];

  int rdy_mode = 0;
  bit stall_ii = 1'b0;
  int ii_cnt = 0;
  int sii_cnt = 0;
  logic [W_II+1:0]  ii_first, ii_at31, ii_last, ii_e;
  logic [W_SII+1:0] sii_first, sii_last, sii_e;

  ii_sii_gen_if #(.W_PIX(W_PIX), .W_II(W_II), .W_SII(W_SII)) bus ();

  ii_sii_gen #(
    .W_PIX(W_PIX), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W_II(W_II), .W_SII(W_SII)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // output sinks: readies change 1 after the rising edge
  initial begin
    bus.ii_ready  = 1'b1;
    bus.sii_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        bus.ii_ready  = ($urandom_range(0, 3) != 0);
        bus.sii_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.ii_ready  = 1'b1;
        bus.sii_ready = 1'b1;
      end
      if (stall_ii) bus.ii_ready = 1'b0;
    end
  end

  // scoreboard: compare each output handshake with the head of its expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ii_valid && bus.ii_ready) begin
        if (ii_exp_q.size() == 0) begin
          check_val("ii_unexpected", 1, 0);
        end else begin
          ii_e = ii_exp_q.pop_front();
          check_val("ii_sample", {bus.ii_eot, bus.ii_data}, ii_e);
        end
        if (ii_cnt == 0)  ii_first = {bus.ii_eot, bus.ii_data};
        if (ii_cnt == 31) ii_at31  = {bus.ii_eot, bus.ii_data};
        ii_last = {bus.ii_eot, bus.ii_data};
        ii_cnt++;
      end
      if (bus.sii_valid && bus.sii_ready) begin
        if (sii_exp_q.size() == 0) begin
          check_val("sii_unexpected", 1, 0);
        end else begin
          sii_e = sii_exp_q.pop_front();
          check_val("sii_sample", {bus.sii_eot, bus.sii_data}, sii_e);
        end
        if (sii_cnt == 0) sii_first = {bus.sii_eot, bus.sii_data};
        sii_last = {bus.sii_eot, bus.sii_data};
        sii_cnt++;
      end
    end
  end

  // kind: 0 all-ones, 1 all-255, 2 ramp x+y, 3 random
  task automatic load_frame(input int kind);
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        case (kind)
          0:       pix[y*IW+x] = 8'd1;
          1:       pix[y*IW+x] = 8'd255;
          2:       pix[y*IW+x] = W_PIX'(x + y);
          default: pix[y*IW+x] = W_PIX'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // reference: 2-D inclusion-exclusion prefix sums over the whole frame
  task automatic push_expected();
    longint a [NPIX];
    longint b [NPIX];
    longint p;
    int i;
    logic [1:0] eot;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        i = y * IW + x;
        p = longint'(pix[i]);
        a[i] = p;
        b[i] = p * p;
        if (x > 0) begin a[i] += a[i-1];  b[i] += b[i-1];  end
        if (y > 0) begin a[i] += a[i-IW]; b[i] += b[i-IW]; end
        if (x > 0 && y > 0) begin a[i] -= a[i-IW-1]; b[i] -= b[i-IW-1]; end
        eot = {(x == IW-1) && (y == IH-1), x == IW-1};
        ii_exp_q.push_back({eot, W_II'(a[i])});
        sii_exp_q.push_back({eot, W_SII'(b[i])});
      end
    end
  endtask

  // pixel driver: present n pixels (optionally with idle gaps), count cycles spent
  task automatic send_pixels(input int n, input bit gaps, output int cycles);
    bit acc;
    int waited;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
          cycles++;
        end
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix[i % NPIX];
      waited = 0;
      do begin
        @(negedge clk);
        acc = bus.pix_ready;
        @(posedge clk);
        #1;
        cycles++;
        waited++;
      end while (!acc && waited < 2000);
      if (!acc) begin
        check_val("pix_accept_timeout", 0, 1);
        break;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((ii_exp_q.size() != 0 || sii_exp_q.size() != 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_val("drain_ii_left", ii_exp_q.size(), 0);
    check_val("drain_sii_left", sii_exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    ii_cnt  = 0;
    sii_cnt = 0;
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int cyc;
    logic [W_II-1:0] hold_data;
    logic [1:0] hold_eot;

    // reset
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ii_valid", bus.ii_valid, 0);
    check_val("rst_sii_valid", bus.sii_valid, 0);
    check_val("rst_ii_data", bus.ii_data, 0);
    check_val("rst_sii_data", bus.sii_data, 0);
    check_val("rst_ii_eot", bus.ii_eot, 0);
    check_val("rst_sii_eot", bus.sii_eot, 0);
    check_val("rst_pix_ready", bus.pix_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: all-ones frame, full throughput
    clear_counts();
    load_frame(0);
    push_expected();
    send_pixels(NPIX, 1'b0, cyc);
    check_val("t1_cycles", cyc, NPIX);
    wait_drain();
    check_val("t1_last_ii", ii_last, {2'b11, 18'd1024});
    check_val("t1_last_sii", sii_last, {2'b11, 26'd1024});
    check_val("t1_count", ii_cnt, NPIX);

    // 2: all-255 frame, widest values
    clear_counts();
    load_frame(1);
    push_expected();
    send_pixels(NPIX, 1'b0, cyc);
    wait_drain();
    check_val("t2_ii_31_0", ii_at31, {2'b01, 18'd8160});
    check_val("t2_last_ii", ii_last, {2'b11, 18'd261120});
    check_val("t2_last_sii", sii_last, {2'b11, 26'd66585600});

    // 3: ii stream stalled for 10 cycles mid-frame
    clear_counts();
    load_frame(2);
    push_expected();
    fork
      send_pixels(NPIX, 1'b0, cyc);
      begin
        repeat (50) @(posedge clk);
        stall_ii = 1'b1;
        @(negedge clk);
        hold_data = bus.ii_data;
        hold_eot  = bus.ii_eot;
        check_val("t3_pix_ready_0", bus.pix_ready, 0);
        check_val("t3_ii_valid_0", bus.ii_valid, 1);
        for (int k = 1; k < 10; k++) begin
          @(negedge clk);
          check_val("t3_pix_ready", bus.pix_ready, 0);
          check_val("t3_ii_valid", bus.ii_valid, 1);
          check_val("t3_ii_data_hold", {bus.ii_eot, bus.ii_data}, {hold_eot, hold_data});
          check_val("t3_sii_valid_low", bus.sii_valid, 0);
        end
        @(posedge clk);
        stall_ii = 1'b0;
      end
    join
    wait_drain();
    check_val("t3_ii_count", ii_cnt, NPIX);
    check_val("t3_sii_count", sii_cnt, NPIX);

    // 4: two back-to-back ramp frames
    clear_counts();
    load_frame(2);
    push_expected();
    push_expected();
    send_pixels(2 * NPIX, 1'b0, cyc);
    check_val("t4_cycles", cyc, 2 * NPIX);
    wait_drain();

    // 5: reset after 100 pixels, then a fresh all-ones frame
    load_frame(0);
    push_expected();
    send_pixels(100, 1'b0, cyc);
    rst = 1'b1;
    ii_exp_q.delete();
    sii_exp_q.delete();
    @(posedge clk);
    #1;
    check_val("t5_ii_valid_after_rst", bus.ii_valid, 0);
    check_val("t5_sii_valid_after_rst", bus.sii_valid, 0);
    rst = 1'b0;
    clear_counts();
    push_expected();
    send_pixels(NPIX, 1'b0, cyc);
    wait_drain();
    check_val("t5_first_ii", ii_first, {2'b00, 18'd1});
    check_val("t5_first_sii", sii_first, {2'b00, 26'd1});

    // 6: random pixels with random gaps on all three streams
    clear_counts();
    load_frame(3);
    push_expected();
    rdy_mode = 1;
    send_pixels(NPIX, 1'b1, cyc);
    wait_drain();
    rdy_mode = 0;
    check_val("t6_ii_count", ii_cnt, NPIX);
    check_val("t6_sii_count", sii_cnt, NPIX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
